sr_ff_bank: RTL and testbench
=============================

Name: sr_ff_bank

Overview:
- Parametrised successor to the single-bit SR flip-flop: WIDTH independent SR channels in one block, sharing one clock and reset.
- Behaviour on S=R=1 is selectable per instance by MODE: hold, set-dominant, reset-dominant or toggle.
- Adds a global clock enable, a synchronous clear, per-channel sticky conflict flags and a saturating conflict-cycle counter.
- Used as a status/flag register bank: event sources set bits, software or control FSMs clear them.

Parameters:
WIDTH, 8, number of SR channels (1..64)
MODE, 1, S=R=1 resolution: 0 = hold, 1 = set-dominant, 2 = reset-dominant, 3 = toggle (JK)
RST_VAL, {WIDTH{1'b0}}, value loaded into q by rst and by clr
CNT_W, 8, width of conflict-cycle counter (2..16)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
en  input  1  clock enable for channel update; clr and counter ignore it
clr  input  1  synchronous clear: q <= RST_VAL, flags and counter <= 0; overrides en, s and r
s  input  WIDTH  per-channel set request
r  input  WIDTH  per-channel reset request
q  output  WIDTH  channel state
qb  output  WIDTH  ~q, combinational from q
conflict  output  WIDTH  sticky per-channel flag: channel saw s=r=1 while en=1
conflict_any  output  1  OR-reduction of conflict
conflict_cnt  output  CNT_W  saturating count of cycles with any s&r bit set while en=1

Behaviour:
- Reset (rst=1, asynchronous):
  - q=RST_VAL, qb=~RST_VAL
  - conflict=0, conflict_any=0, conflict_cnt=0
  - Outputs are held while rst is asserted. First update is at the first rising clk edge after rst deasserts.
- Priority per edge: rst > clr > en.
- With en=0 and clr=0: q, conflict and conflict_cnt all hold. Conflicts are not counted while en=0.
- With en=1 and clr=0, per channel i, at the next rising edge (1-cycle latency):
  - s=0, r=0: hold
  - s=1, r=0: q[i] <= 1
  - s=0, r=1: q[i] <= 0
  - s=1, r=1: MODE 0 hold; MODE 1 q[i] <= 1; MODE 2 q[i] <= 0; MODE 3 q[i] <= ~q[i]
  - conflict[i] <= conflict[i] | (s[i] & r[i])
- Channels are fully independent; mixed requests across bits in the same cycle apply simultaneously.
- conflict_cnt increments by 1 on each en=1 edge where |(s&r)=1:
  - counts cycles, not channels
  - saturates at 2^CNT_W-1 and never wraps
- clr in the same cycle as a conflict: clr wins; counter and flags read 0 afterwards.
- conflict_any is combinational from registered conflict (no extra latency).
- MODE outside 0..3 is an elaboration error (generate-time check).
- No combinational path from s/r/en/clr to any output.

Optional Feature:
- Macro: SR_FF_BANK_EDGE_EN.
- Defined:
  - s and r are registered internally and only rising edges (0->1 between consecutive en=1 cycles) act as requests.
  - A level held high sets/resets once.
  - q latency from the s/r rising edge is still 1 cycle, using the previous-value registers.
  - Previous-value registers reset to 0 and are cleared by clr.
  - Conflict detection uses the edge-detected requests.
- Undefined: level-sensitive behaviour exactly as above.

Test Plan:
- Reset: WIDTH=8, RST_VAL=8'hA5, assert rst mid-cycle -> q=8'hA5, qb=8'h5A, conflict=0, conflict_cnt=0 immediately, without waiting for a clk edge.
- Basic SR: en=1, s=8'h0F, r=8'h00 for one cycle, then s=0, r=8'h03 -> q=8'h0F, then q=8'h0C. qb always ~q.
- Conflict per MODE: q=8'h0C, s=r=8'h05 for one cycle:
  - MODE0 -> q=8'h0C
  - MODE1 -> 8'h0D
  - MODE2 -> 8'h08
  - MODE3 -> 8'h09
  - all modes: conflict=8'h05, conflict_any=1, conflict_cnt=1
- Enable/clear: en=0 with s=8'hFF -> q unchanged, conflict_cnt unchanged. Then clr=1 with s=r=8'hFF, en=1 -> q=RST_VAL, conflict=0, conflict_cnt=0.
- Saturation: CNT_W=2, s=r=8'h01 for 6 cycles -> conflict_cnt sequence 1, 2, 3, 3, 3, 3.
- SR_FF_BANK_EDGE_EN defined:
  - s[0] held high for 4 cycles, r[0] pulsed once in cycle 2 -> q[0]=1 after cycle 1, 0 after cycle 2, stays 0 (no re-set while s[0] stays high).
  - Undefined build, same stimulus -> q[0] returns to 1 in cycle 3.

Source files
------------

// File: rtl/sr_ff_bank.sv
// Bank of WIDTH independent SR flip-flops with selectable S=R=1 resolution, sticky conflict flags
// and a saturating conflict-cycle counter. Define SR_FF_BANK_EDGE_EN to act only on s/r rising edges.
module sr_ff_bank #(
  parameter int               WIDTH   = 8,
  parameter int               MODE    = 1,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic [WIDTH-1:0] conflict,
  output logic             conflict_any,
  output logic [CNT_W-1:0] conflict_cnt
);

  if (MODE < 0 || MODE > 3) begin : g_bad_mode
    $error("sr_ff_bank: MODE must be in 0..3");
  end
  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("sr_ff_bank: WIDTH must be in 1..64");
  end
  if (CNT_W < 2 || CNT_W > 16) begin : g_bad_cnt_w
    $error("sr_ff_bank: CNT_W must be in 2..16");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] conflict_q, conflict_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] s_eff, r_eff;
  logic [WIDTH-1:0] both, set_only, rst_only, base;

`ifdef SR_FF_BANK_EDGE_EN
  logic [WIDTH-1:0] s_prev_q, s_prev_d;
  logic [WIDTH-1:0] r_prev_q, r_prev_d;

  // Previous values only advance on enabled cycles, so an edge spans consecutive en=1 cycles.
  always_comb begin
    s_prev_d = s_prev_q;
    r_prev_d = r_prev_q;
    if (clr) begin
      s_prev_d = '0;
      r_prev_d = '0;
    end else if (en) begin
      s_prev_d = s;
      r_prev_d = r;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_prev_q <= '0;
      r_prev_q <= '0;
    end else begin
      s_prev_q <= s_prev_d;
      r_prev_q <= r_prev_d;
    end
  end

  assign s_eff = s & ~s_prev_q;
  assign r_eff = r & ~r_prev_q;
`else
  assign s_eff = s;
  assign r_eff = r;
`endif

  assign both     = s_eff & r_eff;
  assign set_only = s_eff & ~r_eff;
  assign rst_only = r_eff & ~s_eff;
  assign base     = (q_q | set_only) & ~rst_only;

  always_comb begin
    q_d        = q_q;
    conflict_d = conflict_q;
    cnt_d      = cnt_q;
    if (clr) begin
      q_d        = RST_VAL;
      conflict_d = '0;
      cnt_d      = '0;
    end else if (en) begin
      // Conflicting bits in base still hold q_q; MODE decides what they become.
      case (MODE)
        1:       q_d = base | both;
        2:       q_d = base & ~both;
        3:       q_d = base ^ both;
        default: q_d = base;
      endcase
      conflict_d = conflict_q | both;
      if ((|both) && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q        <= RST_VAL;
      conflict_q <= '0;
      cnt_q      <= '0;
    end else begin
      q_q        <= q_d;
      conflict_q <= conflict_d;
      cnt_q      <= cnt_d;
    end
  end

  assign q            = q_q;
  assign qb           = ~q_q;
  assign conflict     = conflict_q;
  assign conflict_any = |conflict_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_sr_ff_bank.sv
// Scoreboard bench for sr_ff_bank: four instances (MODE 0..3) plus a CNT_W=2 instance share
// one stimulus stream; a behavioural model pushes expected state that is compared after each edge.
module tb_sr_ff_bank;

  localparam int NI = 5;
  localparam logic [7:0] RV = 8'hA5;

  logic clk = 1'b0;
  logic rst, en, clr;
  logic [7:0] s, r;

  logic [7:0] q_o   [NI];
  logic [7:0] qb_o  [NI];
  logic [7:0] cf_o  [NI];
  logic       cfa_o [NI];
  logic [7:0] cnt_o [NI];

  always #5 clk = ~clk;

  for (genvar k = 0; k < NI; k++) begin : g_dut
    localparam int CW = (k == 4) ? 2 : 8;
    localparam int MD = (k == 4) ? 1 : k;
    logic [CW-1:0] cnt_w;
    sr_ff_bank #(.WIDTH(8), .MODE(MD), .RST_VAL(RV), .CNT_W(CW)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .clr          (clr),
      .s            (s),
      .r            (r),
      .q            (q_o[k]),
      .qb           (qb_o[k]),
      .conflict     (cf_o[k]),
      .conflict_any (cfa_o[k]),
      .conflict_cnt (cnt_w)
    );
    assign cnt_o[k] = 8'(cnt_w);
  end

  typedef struct packed {
    logic [NI-1:0][7:0] q;
    logic [NI-1:0][7:0] cf;
    logic [NI-1:0][7:0] cnt;
  } exp_t;

  exp_t sb[$];

  int mode_m [NI] = '{0, 1, 2, 3, 1};
  int sat_m  [NI] = '{255, 255, 255, 255, 3};
  logic [7:0] mq [NI];
  logic [7:0] mcf [NI];
  int mcnt [NI];
  logic [7:0] ps, pr;
  int n_vec = 0;
  int n_err = 0;

  function automatic void model_reset();
    for (int k = 0; k < NI; k++) begin
      mq[k] = RV; mcf[k] = '0; mcnt[k] = 0;
    end
    ps = '0; pr = '0;
  endfunction

  function automatic void model_step(logic e, logic c, logic [7:0] sv, logic [7:0] rv);
    logic [7:0] se, re;
    if (c) begin
      model_reset();
      return;
    end
    if (!e) return;
`ifdef SR_FF_BANK_EDGE_EN
    se = sv & ~ps; re = rv & ~pr;
`else
    se = sv; re = rv;
`endif
    ps = sv; pr = rv;
    for (int k = 0; k < NI; k++) begin
      for (int b = 0; b < 8; b++) begin
        if (se[b] && re[b]) begin
          case (mode_m[k])
            1: mq[k][b] = 1'b1;
            2: mq[k][b] = 1'b0;
            3: mq[k][b] = ~mq[k][b];
            default: ;
          endcase
          mcf[k][b] = 1'b1;
        end else if (se[b]) mq[k][b] = 1'b1;
        else if (re[b]) mq[k][b] = 1'b0;
      end
      if ((se & re) != 8'h00 && mcnt[k] < sat_m[k]) mcnt[k]++;
    end
  endfunction

  function automatic void push_exp();
    exp_t x;
    for (int k = 0; k < NI; k++) begin
      x.q[k] = mq[k]; x.cf[k] = mcf[k]; x.cnt[k] = 8'(mcnt[k]);
    end
    sb.push_back(x);
  endfunction

  task automatic cmp(string tag, int k, logic [7:0] obs, logic [7:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("[TB] FAIL %s[%0d]: observed %h expected %h", tag, k, obs, expv);
    end
  endtask

  task automatic checkOutput();
    exp_t x;
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $error("[TB] FAIL scoreboard: observed empty queue expected an entry");
      return;
    end
    x = sb.pop_front();
    for (int k = 0; k < NI; k++) begin
      cmp("q", k, q_o[k], x.q[k]);
      cmp("qb", k, qb_o[k], ~x.q[k]);
      cmp("conflict", k, cf_o[k], x.cf[k]);
      cmp("conflict_any", k, {7'd0, cfa_o[k]}, {7'd0, |x.cf[k]});
      cmp("conflict_cnt", k, cnt_o[k], x.cnt[k]);
    end
  endtask

  task automatic applyStimulus(logic e, logic c, logic [7:0] sv, logic [7:0] rv);
    @(negedge clk);
    en = e; clr = c; s = sv; r = rv;
    model_step(e, c, sv, rv);
    push_exp();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0; en = 1'b0; clr = 1'b0; s = '0; r = '0;

    // Asynchronous reset asserted mid-cycle, checked before any clock edge.
    #7;
    rst = 1'b1;
    model_reset();
    push_exp();
    #1;
    checkOutput();
    @(posedge clk);
    #1;
    push_exp();
    checkOutput();
    @(negedge clk);
    rst = 1'b0;

    // Clear all bits, then basic set and reset.
    applyStimulus(1'b1, 1'b0, 8'h00, 8'hFF); checkOutput();
    applyStimulus(1'b1, 1'b0, 8'h0F, 8'h00); checkOutput();
    applyStimulus(1'b1, 1'b0, 8'h00, 8'h03); checkOutput();

    // Conflict on bits 0 and 2 from q=0C.
    applyStimulus(1'b1, 1'b0, 8'h05, 8'h05); checkOutput();

    // Disabled cycles hold everything, including conflicts.
    applyStimulus(1'b0, 1'b0, 8'hFF, 8'h00); checkOutput();
    applyStimulus(1'b0, 1'b0, 8'hFF, 8'hFF); checkOutput();

    // Clear beats a simultaneous conflict.
    applyStimulus(1'b1, 1'b1, 8'hFF, 8'hFF); checkOutput();

    // Counter saturation (CNT_W=2 instance stops at 3).
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b0, 8'h01, 8'h01); checkOutput();
    end

    // Mixed random traffic.
    for (int i = 0; i < 24; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0),
                    8'($urandom), 8'($urandom));
      checkOutput();
    end

    // s[0] held for four cycles with a single r[0] pulse in cycle 2.
    applyStimulus(1'b1, 1'b1, 8'h00, 8'h00); checkOutput();
    applyStimulus(1'b1, 1'b0, 8'h00, 8'h01); checkOutput();
    applyStimulus(1'b1, 1'b0, 8'h01, 8'h00); checkOutput();
    applyStimulus(1'b1, 1'b0, 8'h01, 8'h01); checkOutput();
    applyStimulus(1'b1, 1'b0, 8'h01, 8'h00); checkOutput();
    applyStimulus(1'b1, 1'b0, 8'h01, 8'h00); checkOutput();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
